// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for bin2bcd_seq: start/in request, busy/done status,
// registered BCD result with overflow and sign flags.
interface bin2bcd_seq_if #(
  parameter int W      = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [W-1:0]          in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic                  sign;

  modport master (output start, in, input busy, done, bcd, ovf, sign);
  modport slave  (input start, in, output busy, done, bcd, ovf, sign);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, W cycles per result.
// Define BIN2BCD_SIGNED_EN to treat the input as two's complement and report its sign.
module bin2bcd_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   adj;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [W-1:0]    load_val;

`ifdef BIN2BCD_SIGNED_EN
  logic            sign_q, sign_d;
  logic [W:0]      ext;

  // Negate in W+1 bits so the most negative input yields its full magnitude 2^(W-1).
  assign ext      = {bus.in[W-1], bus.in};
  assign load_val = W'(bus.in[W-1] ? -ext : ext);
`else
  assign load_val = bus.in;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    adj     = work_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_d  = sign_q;
`endif

    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          bin_d   = load_val;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = CW'(W);
`ifdef BIN2BCD_SIGNED_EN
          sign_d  = bus.in[W-1];
`endif
        end
      end
      SHIFT: begin
        // The bit leaving the top digit is a carry past 10^DIGITS-1.
        work_d = {adj[BW-2:0], bin_q[W-1]};
        bin_d  = bin_q << 1;
        acc_d  = acc_q | adj[BW-1];
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          bcd_d   = work_d;
          ovf_d   = acc_d;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
  assign bus.sign = sign_q;
`else
  assign bus.sign = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance, expected results
// from a decimal reference model queued at start and compared on every done pulse.
module tb_bin2bcd_seq;

  typedef struct packed {
    logic        sign;
    logic        ovf;
    logic [11:0] bcd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  exp_t q3[$];
  exp_t q2[$];
  int   cyc       = 0;
  int   done_cnt3 = 0;
  int   done_cnt2 = 0;
  int   rise3     = 0;
  int   rise2     = 0;
  int   last_done2 = -1;
  logic busy_prev3 = 1'b0;
  logic busy_prev2 = 1'b0;
  logic [11:0] hold3 = '0;
  logic [7:0]  hold2 = '0;
  bit   b2b2 = 1'b0;

  bin2bcd_seq_if #(.W(8), .DIGITS(3)) bus3 ();
  bin2bcd_seq_if #(.W(8), .DIGITS(2)) bus2 ();

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  bin2bcd_seq #(.W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] v, input int digits);
    exp_t e;
    int   mag;
    int   lim;
    e   = '0;
    mag = int'(v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[7]) begin
      e.sign = 1'b1;
      mag    = 256 - mag;
    end
`endif
    lim = 1;
    for (int i = 0; i < digits; i++) lim *= 10;
    e.ovf = (mag >= lim);
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag /= 10;
    end
    return e;
  endfunction

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q3.delete();
      q2.delete();
      hold3 = '0;
      hold2 = '0;
    end else begin
      if (bus3.busy && !busy_prev3) rise3 = cyc;
      if (bus3.done) begin
        done_cnt3++;
        check("done3_busy_low", 32'(bus3.busy), 32'(0));
        check("done3_latency", 32'(cyc - rise3), 32'(8));
        if (q3.size() == 0) check("done3_unexpected", 32'(1), 32'(0));
        else begin
          e = q3.pop_front();
          check("bcd3", 32'(bus3.bcd), 32'(e.bcd));
          check("ovf3", 32'(bus3.ovf), 32'(e.ovf));
          check("sign3", 32'(bus3.sign), 32'(e.sign));
          hold3 = e.bcd;
        end
      end else begin
        check("bcd3_hold", 32'(bus3.bcd), 32'(hold3));
      end

      if (bus2.busy && !busy_prev2) rise2 = cyc;
      if (bus2.done) begin
        done_cnt2++;
        check("done2_busy_low", 32'(bus2.busy), 32'(0));
        check("done2_latency", 32'(cyc - rise2), 32'(8));
        if (b2b2 && last_done2 >= 0) check("done2_period", 32'(cyc - last_done2), 32'(9));
        last_done2 = b2b2 ? cyc : -1;
        if (q2.size() == 0) check("done2_unexpected", 32'(1), 32'(0));
        else begin
          e = q2.pop_front();
          check("bcd2", 32'(bus2.bcd), 32'(e.bcd[7:0]));
          check("ovf2", 32'(bus2.ovf), 32'(e.ovf));
          hold2 = e.bcd[7:0];
        end
      end else begin
        check("bcd2_hold", 32'(bus2.bcd), 32'(hold2));
      end
    end
    busy_prev3 = bus3.busy;
    busy_prev2 = bus2.busy;
  end

  task automatic go3(input logic [7:0] v, input bit push);
    @(posedge clk); #2;
    bus3.start = 1'b1;
    bus3.in    = v;
    if (push) q3.push_back(model(v, 3));
    @(posedge clk); #2;
    bus3.start = 1'b0;
  endtask

  task automatic go2(input logic [7:0] v);
    @(posedge clk); #2;
    bus2.start = 1'b1;
    bus2.in    = v;
    q2.push_back(model(v, 2));
    @(posedge clk); #2;
    bus2.start = 1'b0;
  endtask

  task automatic wait_dones(input bit two, input int target, input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      if ((two ? done_cnt2 : done_cnt3) >= target) break;
      @(posedge clk);
    end
    #2;
    if (k == 200) check(tag, 32'(0), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus3.start = 1'b0; bus3.in = '0;
    bus2.start = 1'b0; bus2.in = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(bus3.busy), 32'(0));
    check("rst_done", 32'(bus3.done), 32'(0));
    check("rst_bcd", 32'(bus3.bcd), 32'(0));
    check("rst_ovf", 32'(bus3.ovf), 32'(0));
    check("rst_sign", 32'(bus3.sign), 32'(0));
    rst = 1'b0;

    // zero, then full scale followed by a smaller value
    base = done_cnt3; go3(8'd0, 1'b1);   wait_dones(1'b0, base + 1, "timeout_0");
    base = done_cnt3; go3(8'd255, 1'b1); wait_dones(1'b0, base + 1, "timeout_255");
    base = done_cnt3; go3(8'd99, 1'b1);  wait_dones(1'b0, base + 1, "timeout_99");

    // a start pulse during busy must be ignored
    base = done_cnt3;
    go3(8'd123, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    bus3.start = 1'b1; bus3.in = 8'd7;
    @(posedge clk); #2;
    bus3.start = 1'b0; bus3.in = 8'd0;
    wait_dones(1'b0, base + 1, "timeout_123");
    repeat (15) @(posedge clk);
    #2;
    check("single_done_123", 32'(done_cnt3 - base), 32'(1));

    // reset in the middle of a conversion aborts it with no done
    go3(8'd200, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus3.busy), 32'(0));
    check("abort_bcd", 32'(bus3.bcd), 32'(0));
    check("abort_done", 32'(bus3.done), 32'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    base = done_cnt3;
    repeat (15) @(posedge clk);
    #2;
    check("abort_no_done", 32'(done_cnt3 - base), 32'(0));
    base = done_cnt3; go3(8'd42, 1'b1); wait_dones(1'b0, base + 1, "timeout_42");

    // signed-mode boundary values (plain unsigned results when the feature is off)
    base = done_cnt3; go3(8'h80, 1'b1); wait_dones(1'b0, base + 1, "timeout_80");
    base = done_cnt3; go3(8'hFF, 1'b1); wait_dones(1'b0, base + 1, "timeout_ff");
    base = done_cnt3; go3(8'h7F, 1'b1); wait_dones(1'b0, base + 1, "timeout_7f");

    // two-digit instance: overflow, then a fitting value
    base = done_cnt2; go2(8'd200); wait_dones(1'b1, base + 1, "timeout2_200");
    base = done_cnt2; go2(8'd57);  wait_dones(1'b1, base + 1, "timeout2_57");

    // start held high: three back-to-back conversions, one every 9 cycles
    base = done_cnt2;
    b2b2 = 1'b1;
    for (int i = 0; i < 3; i++) q2.push_back(model(8'd31, 2));
    @(posedge clk); #2;
    bus2.start = 1'b1; bus2.in = 8'd31;
    repeat (19) @(posedge clk);
    #2;
    bus2.start = 1'b0;
    wait_dones(1'b1, base + 3, "timeout2_b2b");
    repeat (12) @(posedge clk);
    #2;
    check("b2b_count", 32'(done_cnt2 - base), 32'(3));

    check("q3_drained", 32'(q3.size()), 32'(0));
    check("q2_drained", 32'(q2.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (shift-add-3), one bit per clock.
- Sits directly upstream of the seven-segment decoders: each 4-bit BCD digit it produces drives one decoder instance.
- Start/busy/done handshake; the result stays registered and stable between conversions, so the displays never show intermediate values.

Parameters:
- W, 8, input binary width in bits (legal range 1..16).
- DIGITS, 3, number of BCD output digits (legal range 1..5).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- in  input  W  binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is valid.
- bcd  output  4*DIGITS  result; digit i occupies bits [4i+3:4i], digit 0 is the ones digit.
- ovf  output  1  result exceeded 10^DIGITS-1; valid with done, held with bcd.
- sign  output  1  sign of the last result; constant 0 unless SIGNED_EN is defined.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, ovf=0, sign=0. The internal shift, BCD and counter registers are cleared.
- States:
  - IDLE, SHIFT.
  - IDLE -> SHIFT on a rising edge with start=1.
  - SHIFT -> IDLE on the edge that performs the W-th shift.
- Accept edge (edge k):
  - Load the binary shift register from in.
  - Clear the working BCD register and the overflow accumulator.
  - Set the iteration counter to W.
  - busy=1 from edge k.
- Each SHIFT edge, in order:
  1. For every working digit >= 5, add 3 (4-bit add; no carry into the next digit).
  2. Shift {working BCD, binary} left by 1.
  3. OR the bit shifted out of the top digit into the overflow accumulator.
  4. Decrement the counter.
- Final shift edge (edge k+W):
  - bcd <= final working value; ovf <= accumulator.
  - busy <= 0; done <= 1 for exactly one cycle.
  - Total latency from accept edge to done high: W cycles.
- done is registered and is 0 in all other cycles.
- start is ignored while busy=1; no queuing, no restart.
- start=1 in the cycle done=1 is legal: the FSM is in IDLE, so the new conversion is accepted. bcd holds the old result until the next done.
- Holding start high continuously gives back-to-back conversions, every W+1 cycles.
- in is ignored except on the accept edge; changes during SHIFT have no effect.
- When ovf=1, bcd holds the low DIGITS decimal digits modulo 10^DIGITS (truncated double-dabble result).
- Reset mid-conversion aborts immediately to reset values. No done is produced for the aborted conversion.
- W=8 with DIGITS=3 never overflows. ovf exists for narrower DIGITS configurations.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined:
  - in is two's complement.
  - On the accept edge, sign <= in[W-1] and the shift register is loaded with |in|, computed in W+1 bits so that the most negative value converts correctly. Example: W=8, 0x80 gives magnitude 128.
  - The conversion runs W iterations on the W-bit magnitude, sized to hold 2^(W-1).
  - sign updates on the accept edge and holds until the next accept.
- Not defined:
  - in is unsigned; sign is tied to 0.
  - No extra logic is generated.

Test Plan:
- Reset, then start with in=8'd0 -> done exactly 8 cycles after the accept edge; bcd=12'h000, ovf=0, busy low in the done cycle.
- in=8'd255 -> bcd=12'h255, ovf=0. Then in=8'd99 -> bcd=12'h099, and bcd holds 12'h255 until that done.
- Start with in=8'd123; pulse start again with in=8'd7 at cycle 3 of busy -> second start ignored; bcd=12'h123; exactly one done pulse.
- Assert rst at cycle 4 of a conversion of 8'd200 -> busy=0 and bcd=0 immediately, no done pulse. A following start with in=8'd42 gives bcd=12'h042.
- DIGITS=2, W=8, in=8'd200 -> ovf=1, bcd=8'h00. Then in=8'd57 -> ovf=0, bcd=8'h57. Also hold start high -> done every 9 cycles.
- With BIN2BCD_SIGNED_EN: in=8'h80 -> sign=1, bcd=12'h128; in=8'hFF -> sign=1, bcd=12'h001; in=8'h7F -> sign=0, bcd=12'h127.
